// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU-written bytes are queued in a FIFO
// and shifted out LSB first on tx; exposes DATA/STATUS/DIVISOR/CTRL registers
// and a level interrupt that signals the transmitter has drained.
module uart_tx_mmio #(
    parameter logic [17:0] BASE_ADDR   = 18'h3FF00,
    parameter int unsigned DEPTH       = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mem_we,
    input  logic [17:0] mem_write_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_re,
    input  logic [17:0] mem_read_addr,
    output logic [31:0] mem_read_data,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [17:0] AddrData = BASE_ADDR;
    localparam logic [17:0] AddrStat = BASE_ADDR + 18'd1;
    localparam logic [17:0] AddrDiv  = BASE_ADDR + 18'd2;
    localparam logic [17:0] AddrCtrl = BASE_ADDR + 18'd3;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]    fifo_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          empty, full;
    logic          push_req, push, pop, flush;

    logic [15:0]   div_q, div_eff, div_act_q, baud_q;
    logic          irq_en_q, ovf_q, irq_q;
    logic [31:0]   rdata_q, rd_val;

    state_e        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_idx_q;
    logic          tx_q;
    logic          baud_end, busy;

    // Input bits with no register behind them.
    logic unused_bits;
    assign unused_bits = ^{mem_we[3:2], mem_write_data[31:16]};

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign busy     = (state_q != StIdle);
    assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
    assign baud_end = (baud_q == div_act_q - 16'd1);

    assign push_req = mem_we[0] && (mem_write_addr == AddrData);
    // A full FIFO still accepts a byte when the serializer pops in the same cycle.
    assign push     = push_req && (!full || pop);
    assign pop      = !empty && ((state_q == StIdle) || ((state_q == StStop) && baud_end));
    assign flush    = mem_we[0] && (mem_write_addr == AddrCtrl) && mem_write_data[1];

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= mem_write_data[7:0];
        end
    end

    // FIFO pointers and occupancy; flush drops everything not yet popped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (flush) begin
                rptr_q  <= wptr_q;
                count_q <= '0;
            end else begin
                if (pop) begin
                    rptr_q <= rptr_q + PW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Control/status registers: divisor byte lanes, irq enable, sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= DEFAULT_DIV;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (mem_write_addr == AddrDiv) begin
                if (mem_we[0]) div_q[7:0]  <= mem_write_data[7:0];
                if (mem_we[1]) div_q[15:8] <= mem_write_data[15:8];
            end
            if (mem_we[0] && (mem_write_addr == AddrCtrl)) begin
                irq_en_q <= mem_write_data[0];
            end
            if (push_req && !push) begin
                ovf_q <= 1'b1;
            end else if (mem_we[0] && (mem_write_addr == AddrStat) && mem_write_data[4]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Serializer: start, 8 data bits LSB first, stop; divisor sampled per bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            baud_q    <= 16'd0;
            div_act_q <= 16'd1;
            tx_q      <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q   <= fifo_q[rptr_q];
                        state_q   <= StStart;
                        tx_q      <= 1'b0;
                        baud_q    <= 16'd0;
                        div_act_q <= div_eff;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        state_q   <= StData;
                        tx_q      <= shift_q[0];
                        bit_idx_q <= 3'd0;
                        baud_q    <= 16'd0;
                        div_act_q <= div_eff;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_q    <= 16'd0;
                        div_act_q <= div_eff;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_q    <= 16'd0;
                        div_act_q <= div_eff;
                        if (pop) begin
                            shift_q <= fifo_q[rptr_q];
                            state_q <= StStart;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read mux for the addressed register; unmatched addresses read 0.
    always_comb begin
        rd_val = 32'h0;
        if (mem_read_addr == AddrStat) begin
            rd_val = {23'b0, ovf_q, busy, full, empty, 5'(count_q)};
        end else if (mem_read_addr == AddrDiv) begin
            rd_val = {16'b0, div_q};
        end else if (mem_read_addr == AddrCtrl) begin
            rd_val = {31'b0, irq_en_q};
        end
    end

    // Registered read data and drained-transmitter interrupt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 32'h0;
            irq_q   <= 1'b0;
        end else begin
            if (mem_re) begin
                rdata_q <= rd_val;
            end
            irq_q <= irq_en_q && empty && !busy;
        end
    end

    assign mem_read_data = rdata_q;
    assign tx            = tx_q;
    assign irq           = irq_q;

endmodule
